// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction prefetch engine between the PC source and IF/ID.
// Keeps at most one imem read in flight, buffers {pc, instr} pairs in a DEPTH-entry FIFO
// and hands them to decode over a valid/ready handshake. A redirect flushes the FIFO
// and either restarts fetch at redirect_pc or, if a read is still in flight, marks it stale.
//
// Ports:
//   clk, rst_n                  clock; synchronous active-low reset
//   imem_req/imem_addr          registered read request, held until imem_ack
//   imem_ack/imem_rdata         read completion and data
//   redirect_valid/redirect_pc  flush and restart fetch
//   if_valid/if_ready           decode handshake; if_instr/if_pc carry the FIFO head
//   fifo_count                  FIFO occupancy
//
// Build option: define FETCH_BYPASS_EN to hand an acked instruction straight to decode in
// the same cycle when the FIFO is empty and decode is ready.
module fetch_prefetch_unit #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic                     imem_ack,
    input  logic [DATA_W-1:0]        imem_rdata,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     if_valid,
    input  logic                     if_ready,
    output logic [DATA_W-1:0]        if_instr,
    output logic [ADDR_W-1:0]        if_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    state_e              state_q, state_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   pc_mem_q  [DEPTH];
    logic [DATA_W-1:0]   ins_mem_q [DEPTH];
    logic [PtrW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]     count_q, count_d;

    logic fifo_empty, ack_live, bypass, push, pop;

    assign fifo_empty = (count_q == '0);
    // An ack in StDrop belongs to a stale read and is never buffered.
    assign ack_live   = (state_q == StReq) && imem_ack;

`ifdef FETCH_BYPASS_EN
    assign bypass = fifo_empty && ack_live && if_ready && !redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push    = ack_live && !redirect_valid && !bypass;
    assign pop     = !fifo_empty && if_ready && !redirect_valid;
    assign count_d = redirect_valid ? '0 : (count_q + CntW'(push) - CntW'(pop));

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            if (state_q != StIdle && !imem_ack) begin
                // Read still in flight: hold the bus request, drop its data later.
                state_d = StDrop;
            end else begin
                state_d = StReq;
                req_d   = 1'b1;
                addr_d  = redirect_pc;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (count_q < CntW'(DEPTH)) begin
                        state_d = StReq;
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_q;
                    end
                end
                StReq: begin
                    if (imem_ack) begin
                        fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
                        // Only issue the next read if its data is guaranteed a slot.
                        if (count_d < CntW'(DEPTH)) begin
                            addr_d = fetch_pc_d;
                        end else begin
                            state_d = StIdle;
                            req_d   = 1'b0;
                        end
                    end
                end
                StDrop: begin
                    if (imem_ack) begin
                        state_d = StReq;
                        addr_d  = fetch_pc_q;
                    end
                end
                default: begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            addr_q     <= '0;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            if (redirect_valid) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    pc_mem_q[wr_ptr_q]  <= addr_q;
                    ins_mem_q[wr_ptr_q] <= imem_rdata;
                    wr_ptr_q            <= wr_ptr_q + PtrW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PtrW'(1);
                end
            end
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign fifo_count = count_q;
    assign if_valid   = !fifo_empty || bypass;
    assign if_instr   = bypass ? imem_rdata : ins_mem_q[rd_ptr_q];
    assign if_pc      = bypass ? addr_q : pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
module tb_fetch_prefetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, s_rst_n;
    logic        imem_req, imem_ack, redirect_valid, if_valid, if_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, if_instr, if_pc;
    logic [2:0]  fifo_count;

    // Second instance: 8-bit address space to exercise PC wrap.
    logic        s_req, s_valid;
    logic [7:0]  s_addr, s_pc;
    logic [31:0] s_instr;
    logic [2:0]  s_count;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h100), .PC_STEP(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .fifo_count(fifo_count)
    );

    fetch_prefetch_unit #(
        .ADDR_W(8), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(8'hF8), .PC_STEP(4)
    ) u_wrap (
        .clk(clk), .rst_n(s_rst_n),
        .imem_req(s_req), .imem_addr(s_addr), .imem_ack(s_req),
        .imem_rdata({24'h0, s_addr}), .redirect_valid(1'b0), .redirect_pc(8'h00),
        .if_valid(s_valid), .if_ready(1'b1), .if_instr(s_instr), .if_pc(s_pc),
        .fifo_count(s_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    // Instruction memory: ack after ack_delay waiting cycles of each request.
    logic ack_en = 1'b0;
    int   ack_delay = 0;
    int   ack_total = 0;
    initial begin
        int wait_cnt;
        wait_cnt   = 0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_ack) wait_cnt = 0;
            if (rst_n && ack_en && imem_req) begin
                if (wait_cnt >= ack_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    ack_total++;
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
            end
        end
    end

    // Reference model: a queue of {pc, instr} plus the fetch address and one in-flight flag.
    logic [31:0] mq_pc[$];
    logic [31:0] mq_ins[$];
    logic        m_req = 1'b0, m_stale = 1'b0;
    logic [31:0] m_addr = '0, m_fetch = 32'h100;
    logic        model_on = 1'b0;

    initial begin
        forever begin
            logic ack, byp;
            int   size0;
            @(posedge clk);
            if (!rst_n) begin
                mq_pc.delete();
                mq_ins.delete();
                m_req   = 1'b0;
                m_addr  = '0;
                m_fetch = 32'h100;
                m_stale = 1'b0;
            end else begin
                ack   = imem_ack && m_req;
                size0 = mq_pc.size();
                byp   = 1'b0;
`ifdef FETCH_BYPASS_EN
                byp = (size0 == 0) && ack && !m_stale && if_ready && !redirect_valid;
`endif
                if (redirect_valid) begin
                    mq_pc.delete();
                    mq_ins.delete();
                    m_fetch = redirect_pc;
                    if (m_req && !ack) begin
                        m_stale = 1'b1;
                    end else begin
                        m_stale = 1'b0;
                        m_req   = 1'b1;
                        m_addr  = redirect_pc;
                    end
                end else begin
                    if (size0 > 0 && if_ready) begin
                        void'(mq_pc.pop_front());
                        void'(mq_ins.pop_front());
                    end
                    if (ack) begin
                        if (m_stale) begin
                            m_stale = 1'b0;
                            m_addr  = m_fetch;
                        end else begin
                            if (!byp) begin
                                mq_pc.push_back(m_addr);
                                mq_ins.push_back(imem_rdata);
                            end
                            m_fetch = m_fetch + 32'd4;
                            if (mq_pc.size() < DEPTH) m_addr = m_fetch;
                            else m_req = 1'b0;
                        end
                    end else if (!m_req && size0 < DEPTH) begin
                        m_req  = 1'b1;
                        m_addr = m_fetch;
                    end
                end
            end
            model_on = 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        wait (model_on);
        forever begin
            logic        byp, exp_v;
            logic [31:0] exp_pc, exp_ins;
            @(negedge clk);
            byp = 1'b0;
`ifdef FETCH_BYPASS_EN
            byp = rst_n && (mq_pc.size() == 0) && m_req && !m_stale && imem_ack && if_ready
                  && !redirect_valid;
`endif
            exp_v   = (mq_pc.size() > 0) || byp;
            exp_pc  = byp ? m_addr : ((mq_pc.size() > 0) ? mq_pc[0] : 32'h0);
            exp_ins = byp ? imem_rdata : ((mq_ins.size() > 0) ? mq_ins[0] : 32'h0);
            chk("imem_req", imem_req, m_req);
            if (m_req) chk("imem_addr", imem_addr, m_addr);
            chk("fifo_count", fifo_count, mq_pc.size());
            chk("if_valid", if_valid, exp_v);
            if (exp_v) begin
                chk("if_pc", if_pc, exp_pc);
                chk("if_instr", if_instr, exp_ins);
            end
        end
    end

    // Accepted-instruction logs for directed expectations.
    logic [31:0] acc_log[$];
    logic [7:0]  s_log[$];
    logic [31:0] s_ins_log[$];
    int          s_byp_seen = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && if_valid && if_ready && !redirect_valid) acc_log.push_back(if_pc);
            if (s_rst_n && s_valid) begin
                s_log.push_back(s_pc);
                s_ins_log.push_back(s_instr);
            end
`ifdef FETCH_BYPASS_EN
            if (s_rst_n && s_req && s_byp_seen < 3) begin
                s_byp_seen++;
                chk("wrap_bypass_valid", s_valid, 1'b1);
                chk("wrap_bypass_count", s_count, 3'd0);
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps, l0, i;
        rst_n          = 1'b0;
        s_rst_n        = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset values.
        tick();
        tick();
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_if_valid", if_valid, 1'b0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_fifo_count", fifo_count, 3'd0);

        // Release with decode stalled: first request at RESET_PC, then exactly DEPTH fills.
        ack_total = 0;
        ack_en    = 1'b1;
        ack_delay = 0;
        rst_n     = 1'b1;
        s_rst_n   = 1'b1;
        tick();
        chk("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 32'h100);
        repeat (6) tick();
        chk("bp_fifo_count", fifo_count, 3'd4);
        chk("bp_imem_req", imem_req, 1'b0);
        chk("bp_ack_total", ack_total, 4);

        // Drain and stream.
        if_ready = 1'b1;
        tick();
        tick();
        chk("resume_req", imem_req, 1'b1);
        chk("resume_addr", imem_addr, 32'h110);
        gaps = 0;
        repeat (12) begin
            tick();
            if (!imem_req) gaps++;
        end
        chk("stream_req_held", gaps, 0);
        chk("drain_pc0", acc_log[0], 32'h100);
        chk("drain_pc1", acc_log[1], 32'h104);
        chk("drain_pc2", acc_log[2], 32'h108);
        chk("drain_pc3", acc_log[3], 32'h10C);
        chk("stream_pc4", acc_log[4], 32'h110);
        chk("stream_pc5", acc_log[5], 32'h114);

        // Redirect while a slow read is in flight.
        ack_delay = 3;
        tick();
        for (i = 0; i < 20 && !(imem_req && !imem_ack); i++) tick();
        chk("t4_setup", imem_req && !imem_ack, 1'b1);
        l0             = acc_log.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        tick();
        redirect_valid = 1'b0;
        chk("t4_flush_count", fifo_count, 3'd0);
        chk("t4_flush_valid", if_valid, 1'b0);
        for (i = 0; i < 20 && !(imem_req && imem_addr == 32'h2000); i++) tick();
        chk("t4_req_2000", imem_addr, 32'h2000);
        for (i = 0; i < 20 && acc_log.size() <= l0; i++) tick();
        chk("t4_first_pc", (acc_log.size() > l0) ? acc_log[l0] : 32'hDEAD, 32'h2000);

        // Redirect coinciding with ack and a ready decode stage.
        ack_delay = 0;
        for (i = 0; i < 20 && !(imem_ack && if_valid); i++) tick();
        chk("t5_setup", imem_ack && if_valid, 1'b1);
        l0             = acc_log.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        tick();
        redirect_valid = 1'b0;
        chk("t5_count", fifo_count, 3'd0);
        chk("t5_valid", if_valid, 1'b0);
        chk("t5_req", imem_req, 1'b1);
        chk("t5_addr", imem_addr, 32'h3000);
        for (i = 0; i < 20 && acc_log.size() <= l0; i++) tick();
        chk("t5_first_pc", (acc_log.size() > l0) ? acc_log[l0] : 32'hDEAD, 32'h3000);

        // Reset mid-request.
        chk("t5_midreq", imem_req, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_req", imem_req, 1'b0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_valid", if_valid, 1'b0);
        chk("mid_rst_pc", if_pc, 32'h0);
        chk("mid_rst_instr", if_instr, 32'h0);
        chk("mid_rst_count", fifo_count, 3'd0);
        rst_n = 1'b1;
        repeat (4) tick();

        // 8-bit address wrap on the second instance.
        chk("wrap_log_len", s_log.size() >= 4, 1'b1);
        if (s_log.size() >= 4) begin
            chk("wrap_pc0", s_log[0], 8'hF8);
            chk("wrap_pc1", s_log[1], 8'hFC);
            chk("wrap_pc2", s_log[2], 8'h00);
            chk("wrap_pc3", s_log[3], 8'h04);
            chk("wrap_instr2", s_ins_log[2], 32'h0000_0000);
            chk("wrap_instr3", s_ins_log[3], 32'h0000_0004);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
